id_stage: RTL and testbench

RV32I instruction-decode stage with registered ID/EX pipeline output. Takes the fetched instruction and PC from IF and drives the register-file read ports (`re1/raddr1`, `re2/raddr2`). It consumes `rdata1/rdata2`, applies EX/MEM forwarding, detects load-use hazards, and presents decoded operands to EX one cycle later. The register file supplies x0 = 0 and WB-to-read bypass; this block does not duplicate either.

---
 rtl/id_stage_pkg.sv | 64 ++++++
 rtl/id_stage_if.sv | 68 ++++++
 rtl/id_stage_imm_gen.sv | 36 +++
 rtl/id_stage.sv | 166 ++++++++++++++++
 tb/tb_id_stage.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg
// Shared definitions for the RV32I decode stage: bus widths, op-class
// encoding handed to EX, the major opcodes recognised by decode, and the
// ID/EX register layout together with its bubble value.
package id_stage_pkg;

  localparam int DataBus    = 32;
  localparam int RegAddrBus = 5;

  // Op class as seen by EX; NOP doubles as the bubble/illegal class
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ALU    = 4'd1,
    OP_ALUI   = 4'd2,
    OP_LUI    = 4'd3,
    OP_AUIPC  = 4'd4,
    OP_JAL    = 4'd5,
    OP_JALR   = 4'd6,
    OP_BRANCH = 4'd7,
    OP_LOAD   = 4'd8,
    OP_STORE  = 4'd9
  } op_e;

  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic                  valid;
    op_e                   op;
    logic [2:0]            funct3;
    logic                  f7b5;
    logic [DataBus-1:0]    reg1;
    logic [DataBus-1:0]    reg2;
    logic [DataBus-1:0]    imm;
    logic [DataBus-1:0]    pc;
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic                  illegal;
  } idex_t;

  // A bubble is an all-zero register: invalid, NOP, no write, not illegal
  localparam idex_t IDEX_BUBBLE = '{
    valid:   1'b0,
    op:      OP_NOP,
    funct3:  3'd0,
    f7b5:    1'b0,
    reg1:    '0,
    reg2:    '0,
    imm:     '0,
    pc:      '0,
    wd:      '0,
    wreg:    1'b0,
    illegal: 1'b0
  };

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if
// Bundle of every signal between the decode stage and its neighbours
// (IF, register file, EX/MEM forwarding, EX consumer).
// Modports:
//   slave  - the decode stage itself
//   master - the surrounding pipeline (IF, register file, EX, MEM)
interface id_stage_if;
  import id_stage_pkg::*;

  // IF side
  logic                  if_valid;
  logic [DataBus-1:0]    if_pc;
  logic [DataBus-1:0]    if_inst;
  logic                  id_stall;

  // Pipeline control from EX
  logic                  flush;
  logic                  ex_stall;

  // Register-file read ports
  logic                  re1;
  logic                  re2;
  logic [RegAddrBus-1:0] raddr1;
  logic [RegAddrBus-1:0] raddr2;
  logic [DataBus-1:0]    rdata1;
  logic [DataBus-1:0]    rdata2;

  // Forwarding sources
  logic                  fwd_ex_wreg;
  logic [RegAddrBus-1:0] fwd_ex_wd;
  logic [DataBus-1:0]    fwd_ex_wdata;
  logic                  fwd_ex_is_load;
  logic                  fwd_mem_wreg;
  logic [RegAddrBus-1:0] fwd_mem_wd;
  logic [DataBus-1:0]    fwd_mem_wdata;

  // ID/EX register
  logic                  idex_valid;
  logic [3:0]            idex_op;
  logic [2:0]            idex_funct3;
  logic                  idex_f7b5;
  logic [DataBus-1:0]    idex_reg1;
  logic [DataBus-1:0]    idex_reg2;
  logic [DataBus-1:0]    idex_imm;
  logic [DataBus-1:0]    idex_pc;
  logic [RegAddrBus-1:0] idex_wd;
  logic                  idex_wreg;
  logic                  idex_illegal;

  modport slave (
    input  if_valid, if_pc, if_inst, flush, ex_stall, rdata1, rdata2,
           fwd_ex_wreg, fwd_ex_wd, fwd_ex_wdata, fwd_ex_is_load,
           fwd_mem_wreg, fwd_mem_wd, fwd_mem_wdata,
    output id_stall, re1, re2, raddr1, raddr2,
           idex_valid, idex_op, idex_funct3, idex_f7b5, idex_reg1, idex_reg2,
           idex_imm, idex_pc, idex_wd, idex_wreg, idex_illegal
  );

  modport master (
    output if_valid, if_pc, if_inst, flush, ex_stall, rdata1, rdata2,
           fwd_ex_wreg, fwd_ex_wd, fwd_ex_wdata, fwd_ex_is_load,
           fwd_mem_wreg, fwd_mem_wd, fwd_mem_wdata,
    input  id_stall, re1, re2, raddr1, raddr2,
           idex_valid, idex_op, idex_funct3, idex_f7b5, idex_reg1, idex_reg2,
           idex_imm, idex_pc, idex_wd, idex_wreg, idex_illegal
  );

endinterface

// File: rtl/id_stage_imm_gen.sv
// imm_gen
// Combinational RV32I immediate generator. Selects the I/S/B/U/J format
// from the opcode and returns the sign-extended immediate; opcodes with no
// immediate produce 0.
// Ports:
//   inst_i - 32-bit instruction word
//   imm_o  - 32-bit immediate
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [DataBus-1:0] inst_i,
  output logic [DataBus-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (inst_i[6:0])
      OPC_ALUI, OPC_JALR, OPC_LOAD:
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      OPC_STORE:
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      // Branch and jump offsets are halfword-aligned, so bit 0 is implicit
      OPC_BRANCH:
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {inst_i[31:12], 12'd0};
      OPC_JAL:
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage
// RV32I decode stage. Decodes the instruction from IF, drives the register
// file read ports, resolves source operands with EX/MEM forwarding, detects
// load-use hazards and registers the decoded instruction into ID/EX.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset (clears the ID/EX register)
//   bus - id_stage_if.slave: IF inputs, id_stall, register-file ports,
//         forwarding inputs, flush/ex_stall, and the idex_* outputs
module id_stage
  import id_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  logic [DataBus-1:0]    inst;
  logic [RegAddrBus-1:0] rs1;
  logic [RegAddrBus-1:0] rs2;
  logic [RegAddrBus-1:0] rd;
  logic [DataBus-1:0]    imm;

  op_e  decOp;
  logic decLegal;
  logic useRs1;
  logic useRs2;
  logic writesRd;

  logic               readEn1;
  logic               readEn2;
  logic [DataBus-1:0] operand1;
  logic [DataBus-1:0] operand2;
  logic               loadUse;

  idex_t decoded;
  idex_t idex_d;
  idex_t idex_q;

  assign inst = bus.if_inst;
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign rd   = inst[11:7];

  imm_gen u_imm_gen (
    .inst_i (inst),
    .imm_o  (imm)
  );

  // Opcode to op class plus which register fields the class actually uses
  always_comb begin
    decOp    = OP_NOP;
    decLegal = 1'b1;
    useRs1   = 1'b0;
    useRs2   = 1'b0;
    writesRd = 1'b0;
    case (inst[6:0])
      OPC_ALU:    begin decOp = OP_ALU;    useRs1 = 1'b1; useRs2 = 1'b1; writesRd = 1'b1; end
      OPC_ALUI:   begin decOp = OP_ALUI;   useRs1 = 1'b1; writesRd = 1'b1; end
      OPC_LUI:    begin decOp = OP_LUI;    writesRd = 1'b1; end
      OPC_AUIPC:  begin decOp = OP_AUIPC;  writesRd = 1'b1; end
      OPC_JAL:    begin decOp = OP_JAL;    writesRd = 1'b1; end
      OPC_JALR:   begin decOp = OP_JALR;   useRs1 = 1'b1; writesRd = 1'b1; end
      OPC_BRANCH: begin decOp = OP_BRANCH; useRs1 = 1'b1; useRs2 = 1'b1; end
      OPC_LOAD:   begin decOp = OP_LOAD;   useRs1 = 1'b1; writesRd = 1'b1; end
      OPC_STORE:  begin decOp = OP_STORE;  useRs1 = 1'b1; useRs2 = 1'b1; end
      default:    decLegal = 1'b0;
    endcase
  end

  assign readEn1 = bus.if_valid & useRs1;
  assign readEn2 = bus.if_valid & useRs2;

  assign bus.re1    = readEn1;
  assign bus.re2    = readEn2;
  assign bus.raddr1 = rs1;
  assign bus.raddr2 = rs2;

  // EX is newer than MEM, so it takes precedence; x0 never forwards because
  // the register file already returns zero for it
  function automatic logic [DataBus-1:0] resolveOperand(
    input logic                  en,
    input logic [RegAddrBus-1:0] addr,
    input logic [DataBus-1:0]    rdata,
    input logic                  exWreg,
    input logic [RegAddrBus-1:0] exWd,
    input logic [DataBus-1:0]    exData,
    input logic                  memWreg,
    input logic [RegAddrBus-1:0] memWd,
    input logic [DataBus-1:0]    memData
  );
    if (!en || addr == '0)
      return '0;
    else if (exWreg && exWd == addr)
      return exData;
    else if (memWreg && memWd == addr)
      return memData;
    else
      return rdata;
  endfunction

  always_comb begin
    operand1 = resolveOperand(readEn1, rs1, bus.rdata1,
                              bus.fwd_ex_wreg, bus.fwd_ex_wd, bus.fwd_ex_wdata,
                              bus.fwd_mem_wreg, bus.fwd_mem_wd, bus.fwd_mem_wdata);
    operand2 = resolveOperand(readEn2, rs2, bus.rdata2,
                              bus.fwd_ex_wreg, bus.fwd_ex_wd, bus.fwd_ex_wdata,
                              bus.fwd_mem_wreg, bus.fwd_mem_wd, bus.fwd_mem_wdata);
  end

  // A load in EX has no data yet; the consumer waits one cycle and then
  // picks the value up from the MEM forward
  assign loadUse = bus.fwd_ex_is_load && bus.fwd_ex_wreg && (bus.fwd_ex_wd != '0) &&
                   ((readEn1 && bus.fwd_ex_wd == rs1) || (readEn2 && bus.fwd_ex_wd == rs2));

  // A flush discards the ID instruction, so IF must be free to redirect
  assign bus.id_stall = bus.if_valid && !bus.flush && (bus.ex_stall || loadUse);

  always_comb begin
    decoded         = IDEX_BUBBLE;
    decoded.valid   = 1'b1;
    decoded.op      = decOp;
    decoded.funct3  = inst[14:12];
    decoded.f7b5    = inst[30];
    decoded.reg1    = operand1;
    decoded.reg2    = operand2;
    decoded.imm     = imm;
    decoded.pc      = bus.if_pc;
    decoded.wd      = rd;
    decoded.wreg    = writesRd && (rd != '0);
    decoded.illegal = !decLegal;
  end

  // Flush beats a downstream hold, which beats hazard/empty bubbles
  always_comb begin
    idex_d = idex_q;
    if (bus.flush)
      idex_d = IDEX_BUBBLE;
    else if (bus.ex_stall)
      idex_d = idex_q;
    else if (loadUse || !bus.if_valid)
      idex_d = IDEX_BUBBLE;
    else
      idex_d = decoded;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      idex_q <= IDEX_BUBBLE;
    else
      idex_q <= idex_d;
  end

  assign bus.idex_valid   = idex_q.valid;
  assign bus.idex_op      = idex_q.op;
  assign bus.idex_funct3  = idex_q.funct3;
  assign bus.idex_f7b5    = idex_q.f7b5;
  assign bus.idex_reg1    = idex_q.reg1;
  assign bus.idex_reg2    = idex_q.reg2;
  assign bus.idex_imm     = idex_q.imm;
  assign bus.idex_pc      = idex_q.pc;
  assign bus.idex_wd      = idex_q.wd;
  assign bus.idex_wreg    = idex_q.wreg;
  assign bus.idex_illegal = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
// Scoreboard bench for id_stage: directed cases followed by random traffic.
// Expected ID/EX contents come from a reference model of the decode rules.
`timescale 1ns/1ps
module tb_id_stage;

  logic clk;
  logic rst;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int          op;
    bit [2:0]    funct3;
    bit          f7b5;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [31:0] pc;
    bit [4:0]    wd;
    bit          wreg;
    bit          illegal;
  } expT;

  expT scoreboard[$];
  expT modelQ;
  expT zeroExp;

  int checks = 0;
  int errors = 0;

  // Stimulus variables, copied onto the bus by applyStimulus
  logic        sValid, sFlush, sExStall;
  logic [31:0] sPc, sInst, sRdata1, sRdata2;
  logic        exW, exLoad, memW;
  logic [4:0]  exWd, memWd;
  logic [31:0] exData, memData;

  // Op class numbering follows the EX interface; -1 marks an unknown opcode
  function automatic int opClass(input logic [31:0] inst);
    case (inst[6:0])
      7'h33: return 1;
      7'h13: return 2;
      7'h37: return 3;
      7'h17: return 4;
      7'h6F: return 5;
      7'h67: return 6;
      7'h63: return 7;
      7'h03: return 8;
      7'h23: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic bit readsRs1(input int cls);
    return cls inside {1, 2, 6, 7, 8, 9};
  endfunction

  function automatic bit readsRs2(input int cls);
    return cls inside {1, 7, 9};
  endfunction

  function automatic bit writesRd(input int cls);
    return cls inside {1, 2, 3, 4, 5, 6, 8};
  endfunction

  // Immediates assembled with arithmetic weights; sgn supplies sign extension
  function automatic logic [31:0] refImm(input int cls, input logic [31:0] inst);
    int sgn;
    sgn = inst[31] ? -1 : 0;
    case (cls)
      2, 6, 8: return 32'($signed(inst) >>> 20);
      9:       return 32'(sgn * 4096 + int'(inst[31:25]) * 32 + int'(inst[11:7]));
      7:       return 32'(sgn * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
                          + int'(inst[11:8]) * 2);
      3, 4:    return inst & 32'hFFFFF000;
      5:       return 32'(sgn * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
                          + int'(inst[30:21]) * 2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] refOperand(input bit en, input logic [4:0] addr,
                                             input logic [31:0] rdata);
    if (!en || addr == 5'd0) return 32'd0;
    if (exW && exWd == addr) return exData;
    if (memW && memWd == addr) return memData;
    return rdata;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the whole ID/EX register against one expected entry
  task automatic checkOutput(input expT e, input string tag);
    checkValue({tag, ".valid"},   32'(bus.idex_valid),   32'(e.valid));
    checkValue({tag, ".op"},      32'(bus.idex_op),      32'(e.op));
    checkValue({tag, ".funct3"},  32'(bus.idex_funct3),  32'(e.funct3));
    checkValue({tag, ".f7b5"},    32'(bus.idex_f7b5),    32'(e.f7b5));
    checkValue({tag, ".reg1"},    bus.idex_reg1,         e.reg1);
    checkValue({tag, ".reg2"},    bus.idex_reg2,         e.reg2);
    checkValue({tag, ".imm"},     bus.idex_imm,          e.imm);
    checkValue({tag, ".pc"},      bus.idex_pc,           e.pc);
    checkValue({tag, ".wd"},      32'(bus.idex_wd),      32'(e.wd));
    checkValue({tag, ".wreg"},    32'(bus.idex_wreg),    32'(e.wreg));
    checkValue({tag, ".illegal"}, 32'(bus.idex_illegal), 32'(e.illegal));
  endtask

  // Drives one cycle at the falling edge, checks the combinational outputs,
  // and queues what ID/EX must hold after the next rising edge
  task automatic applyStimulus();
    expT nxt;
    int  cls;
    bit  r1, r2, haz, stall;
    logic [4:0] a1, a2, rdField;
    @(negedge clk);
    rst                = 1'b1;
    bus.if_valid       = sValid;
    bus.if_pc          = sPc;
    bus.if_inst        = sInst;
    bus.flush          = sFlush;
    bus.ex_stall       = sExStall;
    bus.rdata1         = sRdata1;
    bus.rdata2         = sRdata2;
    bus.fwd_ex_wreg    = exW;
    bus.fwd_ex_wd      = exWd;
    bus.fwd_ex_wdata   = exData;
    bus.fwd_ex_is_load = exLoad;
    bus.fwd_mem_wreg   = memW;
    bus.fwd_mem_wd     = memWd;
    bus.fwd_mem_wdata  = memData;

    cls     = opClass(sInst);
    a1      = sInst[19:15];
    a2      = sInst[24:20];
    rdField = sInst[11:7];
    r1      = sValid && readsRs1(cls);
    r2      = sValid && readsRs2(cls);
    haz     = exLoad && exW && exWd != 5'd0 && ((r1 && exWd == a1) || (r2 && exWd == a2));
    stall   = sValid && !sFlush && (sExStall || haz);

    if (sFlush)                nxt = zeroExp;
    else if (sExStall)         nxt = modelQ;
    else if (haz || !sValid)   nxt = zeroExp;
    else begin
      nxt.valid   = 1'b1;
      nxt.op      = (cls < 0) ? 0 : cls;
      nxt.funct3  = sInst[14:12];
      nxt.f7b5    = sInst[30];
      nxt.reg1    = refOperand(r1, a1, sRdata1);
      nxt.reg2    = refOperand(r2, a2, sRdata2);
      nxt.imm     = refImm(cls, sInst);
      nxt.pc      = sPc;
      nxt.wd      = rdField;
      nxt.wreg    = writesRd(cls) && rdField != 5'd0;
      nxt.illegal = (cls < 0);
    end
    scoreboard.push_back(nxt);
    modelQ = nxt;

    #1;
    checkValue("id_stall", 32'(bus.id_stall), 32'(stall));
    checkValue("re1",      32'(bus.re1),      32'(r1));
    checkValue("re2",      32'(bus.re2),      32'(r2));
    checkValue("raddr1",   32'(bus.raddr1),   32'(a1));
    checkValue("raddr2",   32'(bus.raddr2),   32'(a2));
  endtask

  task automatic clearInputs();
    sValid = 1'b0; sFlush = 1'b0; sExStall = 1'b0;
    sPc = 32'd0; sInst = 32'h00000013; sRdata1 = 32'd0; sRdata2 = 32'd0;
    exW = 1'b0; exLoad = 1'b0; exWd = 5'd0; exData = 32'd0;
    memW = 1'b0; memWd = 5'd0; memData = 32'd0;
  endtask

  // Asynchronous reset away from any clock edge; ID/EX must clear at once
  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput(zeroExp, "reset_async");
    modelQ = zeroExp;
    @(posedge clk);
    #1;
    checkOutput(zeroExp, "reset_hold");
  endtask

  task automatic randomizeInputs();
    int kind;
    logic [6:0] opc;
    logic [6:0] legalOpc [9];
    legalOpc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    kind = int'($urandom_range(0, 10));
    if (kind < 9) opc = legalOpc[kind];
    else begin
      opc = 7'($urandom);
      while (opClass({25'd0, opc}) >= 0) opc = 7'($urandom);
    end
    sInst        = $urandom;
    sInst[6:0]   = opc;
    sInst[11:7]  = 5'($urandom_range(0, 5));
    sInst[19:15] = 5'($urandom_range(0, 4));
    sInst[24:20] = 5'($urandom_range(0, 4));
    sValid   = ($urandom_range(0, 99) < 85);
    sFlush   = ($urandom_range(0, 99) < 8);
    sExStall = ($urandom_range(0, 99) < 15);
    sPc      = $urandom & 32'hFFFFFFFC;
    sRdata1  = $urandom;
    sRdata2  = $urandom;
    exW      = ($urandom_range(0, 99) < 70);
    exLoad   = ($urandom_range(0, 99) < 35);
    exWd     = 5'($urandom_range(0, 4));
    exData   = $urandom;
    memW     = ($urandom_range(0, 99) < 70);
    memWd    = 5'($urandom_range(0, 4));
    memData  = $urandom;
  endtask

  // Monitor: one registered result per rising edge while out of reset
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e, "idex");
      end
    end
  end

  initial begin
    zeroExp = '{valid: 1'b0, op: 0, funct3: 3'd0, f7b5: 1'b0, reg1: 32'd0, reg2: 32'd0,
                imm: 32'd0, pc: 32'd0, wd: 5'd0, wreg: 1'b0, illegal: 1'b0};
    modelQ = zeroExp;
    clearInputs();
    rst = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = 32'd0; bus.if_inst = 32'd0;
    bus.flush = 1'b0; bus.ex_stall = 1'b0; bus.rdata1 = 32'd0; bus.rdata2 = 32'd0;
    bus.fwd_ex_wreg = 1'b0; bus.fwd_ex_wd = 5'd0; bus.fwd_ex_wdata = 32'd0;
    bus.fwd_ex_is_load = 1'b0; bus.fwd_mem_wreg = 1'b0; bus.fwd_mem_wd = 5'd0;
    bus.fwd_mem_wdata = 32'd0;
    @(posedge clk);
    #1;
    checkOutput(zeroExp, "reset_initial");

    // addi x5,x0,-1
    clearInputs();
    sValid = 1'b1; sPc = 32'h100; sInst = 32'hFFF00293;
    applyStimulus();

    // add x3,x1,x2 with both forwards on x1; EX must win
    clearInputs();
    sValid = 1'b1; sPc = 32'h104; sInst = 32'h002081B3; sRdata1 = 32'h55; sRdata2 = 32'h33;
    exW = 1'b1; exWd = 5'd1; exData = 32'h11;
    memW = 1'b1; memWd = 5'd1; memData = 32'h22;
    applyStimulus();

    // lw x4 in EX, sub x6,x4,x7 in ID: one bubble, then MEM forward
    clearInputs();
    sValid = 1'b1; sPc = 32'h108; sInst = 32'h40720333; sRdata1 = 32'h9; sRdata2 = 32'h77;
    exW = 1'b1; exLoad = 1'b1; exWd = 5'd4; exData = 32'hDEAD;
    applyStimulus();
    exW = 1'b0; exLoad = 1'b0;
    memW = 1'b1; memWd = 5'd4; memData = 32'h4444;
    applyStimulus();

    // Flush coinciding with a load-use hazard
    exW = 1'b1; exLoad = 1'b1; exWd = 5'd4; memW = 1'b0;
    sFlush = 1'b1;
    applyStimulus();

    // Valid instruction, then three cycles of downstream hold
    clearInputs();
    sValid = 1'b1; sPc = 32'h200; sInst = 32'hFFF00293;
    applyStimulus();
    sExStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sPc = 32'h204 + 32'(i * 4); sInst = 32'h002081B3; sRdata1 = 32'(i + 1);
      applyStimulus();
    end
    // Flush together with a hold still loads a bubble
    sFlush = 1'b1;
    applyStimulus();

    // Unknown opcode, then jal x0,-4
    clearInputs();
    sValid = 1'b1; sPc = 32'h300; sInst = 32'h0000007F;
    applyStimulus();
    sPc = 32'h304; sInst = 32'hFFDFF06F;
    applyStimulus();

    for (int n = 0; n < 600; n++) begin
      if (n == 300) doReset();
      randomizeInputs();
      applyStimulus();
    end

    @(posedge clk);
    #2;
    checkValue("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
